// File: rtl/fir_sched_pkg.sv
// Shared types and elaboration-time helpers for the FIR engine scheduler.
package fir_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_STALL = 2'd3
   } sched_state_t;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Bit k of the result is bit bit_pos of the integer k; used to encode one-hot to binary.
   function automatic logic [15:0] idx_bit_mask(input int bit_pos);
      logic [15:0] m;
      m = '0;
      for (int k = 15; k >= 0; k--) begin
         m = {m[14:0], 1'(k >> bit_pos)};
      end
      return m;
   endfunction

endpackage

// File: rtl/fir_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after ptr_i, wrapping.
module fir_rr_arbiter
   import fir_sched_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int CH_W   = ch_width(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [CH_W-1:0]   ptr_i,
   output logic              grant_valid_o,
   output logic [CH_W-1:0]   grant_idx_o
);

   localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(NUM_CH);

   logic [2*NUM_CH-1:0] req_dbl;
   logic [NUM_CH-1:0]   req_rot;
   logic [NUM_CH-1:0]   first_hot;
   logic [CH_W-1:0]     offset;
   logic [CH_W:0]       idx_sum;

   // Rotate so that bit 0 is the channel at ptr_i.
   assign req_dbl = {req_i, req_i};
   assign req_rot = NUM_CH'(req_dbl >> ptr_i);

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_first
         localparam logic [NUM_CH-1:0] BELOW = NUM_CH'((32'd1 << gi) - 32'd1);
         assign first_hot[gi] = req_rot[gi] & ~(|(req_rot & BELOW));
      end
      for (genvar gi = 0; gi < CH_W; gi++) begin : g_enc
         localparam logic [NUM_CH-1:0] SEL = NUM_CH'(idx_bit_mask(gi));
         assign offset[gi] = |(first_hot & SEL);
      end
   endgenerate

   assign grant_valid_o = |req_i;
   assign idx_sum       = {1'b0, ptr_i} + {1'b0, offset};
   assign grant_idx_o   = CH_W'((idx_sum >= CH_LIM) ? (idx_sum - CH_LIM) : idx_sum);

endmodule

// File: rtl/fir_engine_scheduler.sv
// Time-shares one FIR MAC engine across NUM_CH sample streams with per-channel
// decimation and a single tagged output register.
module fir_engine_scheduler
   import fir_sched_pkg::*;
#(
   parameter int NUM_CH            = 2,
   parameter int DATA_WIDTH        = 32,
   parameter int DECIMATION_FACTOR = 1,
   localparam int CH_W             = ch_width(NUM_CH)
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NUM_CH-1:0]                   ch_valid_i,
   input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]   ch_data_i,
   output logic [NUM_CH-1:0]                   ch_ready_o,
   output logic                                eng_start_o,
   output logic [CH_W-1:0]                     eng_ch_o,
   output logic [DATA_WIDTH-1:0]               eng_sample_o,
   output logic                                eng_compute_o,
   input  logic                                eng_done_i,
   input  logic [DATA_WIDTH-1:0]               eng_result_i,
   output logic                                out_valid_o,
   output logic [CH_W-1:0]                     out_ch_o,
   output logic [DATA_WIDTH-1:0]               out_data_o,
   input  logic                                out_ready_i
);

   localparam logic [7:0] DEC_LAST = 8'(DECIMATION_FACTOR - 1);

   sched_state_t          state_q;
   logic [CH_W-1:0]       rr_ptr_q;
   logic                  slot_full_q [NUM_CH];
   logic [DATA_WIDTH-1:0] slot_data_q [NUM_CH];
   logic [7:0]            dec_cnt_q   [NUM_CH];
   logic [NUM_CH-1:0]     slot_req;
   logic [NUM_CH-1:0]     is_last;

   logic                  eng_start_q;
   logic [CH_W-1:0]       eng_ch_q;
   logic [DATA_WIDTH-1:0] eng_sample_q;
   logic                  eng_compute_q;
   logic                  out_valid_q;
   logic [CH_W-1:0]       out_ch_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic [DATA_WIDTH-1:0] pend_data_q;

   logic                  grant_valid;
   logic [CH_W-1:0]       grant_idx;
   logic                  grant_fire;
   logic [CH_W-1:0]       rr_ptr_d;
   logic                  out_free;
   logic                  out_load;
   logic [DATA_WIDTH-1:0] out_load_data;

   fir_rr_arbiter #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_arb (
      .req_i         (slot_req),
      .ptr_i         (rr_ptr_q),
      .grant_valid_o (grant_valid),
      .grant_idx_o   (grant_idx)
   );

   assign grant_fire = (state_q == S_IDLE) && grant_valid;
   assign rr_ptr_d   = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic granted;
         assign granted       = grant_fire && (grant_idx == CH_W'(gi));
         assign slot_req[gi]  = slot_full_q[gi];
         assign ch_ready_o[gi] = ~slot_full_q[gi];
         assign is_last[gi]   = (dec_cnt_q[gi] == DEC_LAST);

         // Grant and accept are exclusive: grant needs a full slot, accept an empty one.
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               slot_full_q[gi] <= 1'b0;
               slot_data_q[gi] <= '0;
               dec_cnt_q[gi]   <= '0;
            end else if (granted) begin
               slot_full_q[gi] <= 1'b0;
               dec_cnt_q[gi]   <= is_last[gi] ? 8'd0 : dec_cnt_q[gi] + 8'd1;
            end else if (ch_valid_i[gi] && !slot_full_q[gi]) begin
               slot_full_q[gi] <= 1'b1;
               slot_data_q[gi] <= ch_data_i[gi];
            end
         end
      end
   endgenerate

   assign out_free      = !out_valid_q || out_ready_i;
   assign out_load      = ((state_q == S_WAIT) && eng_done_i && eng_compute_q && out_free)
                       || ((state_q == S_STALL) && out_free);
   assign out_load_data = (state_q == S_STALL) ? pend_data_q : eng_result_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         rr_ptr_q      <= '0;
         eng_start_q   <= 1'b0;
         eng_ch_q      <= '0;
         eng_sample_q  <= '0;
         eng_compute_q <= 1'b0;
         out_valid_q   <= 1'b0;
         out_ch_q      <= '0;
         out_data_q    <= '0;
         pend_data_q   <= '0;
      end else begin
         eng_start_q <= 1'b0;

         // eng_ch_q is stable from grant to next grant, so it tags both direct and pending loads.
         if (out_load) begin
            out_valid_q <= 1'b1;
            out_ch_q    <= eng_ch_q;
            out_data_q  <= out_load_data;
         end else if (out_valid_q && out_ready_i) begin
            out_valid_q <= 1'b0;
         end

         case (state_q)
            S_IDLE: begin
               if (grant_valid) begin
                  eng_ch_q      <= grant_idx;
                  eng_sample_q  <= slot_data_q[grant_idx];
                  eng_compute_q <= is_last[grant_idx];
                  eng_start_q   <= 1'b1;
                  rr_ptr_q      <= rr_ptr_d;
                  state_q       <= S_ISSUE;
               end
            end
            S_ISSUE: state_q <= S_WAIT;
            S_WAIT: begin
               if (eng_done_i) begin
                  if (!eng_compute_q || out_free) begin
                     state_q <= S_IDLE;
                  end else begin
                     pend_data_q <= eng_result_i;
                     state_q     <= S_STALL;
                  end
               end
            end
            S_STALL: begin
               if (out_free) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign eng_start_o   = eng_start_q;
   assign eng_ch_o      = eng_ch_q;
   assign eng_sample_o  = eng_sample_q;
   assign eng_compute_o = eng_compute_q;
   assign out_valid_o   = out_valid_q;
   assign out_ch_o      = out_ch_q;
   assign out_data_o    = out_data_q;

endmodule
